lcd_value_display: RTL

Upstream feeder for the LCD text sender. Captures an unsigned binary value plus a 16-character title, converts the value to decimal with a sequential double-dabble, and formats two 16-character ASCII lines. It then pulses sendText and holds both lines stable until the sender reports sendingDone. Later updates are coalesced so that only the latest value is displayed.

---
 rtl/lcd_value_display_if.sv | 33 +++
 rtl/lcd_value_display.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/lcd_value_display_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lcd_value_display_if
// Purpose  : Value/title request and LCD text-sender handshake bundle.
// Revision : 1.0
// ============================================================================
interface lcd_value_display_if #(
    parameter int LINE_LENGTH = 16,
    parameter int VALUE_WIDTH = 16
);
    logic [VALUE_WIDTH-1:0]   value;
    logic [8*LINE_LENGTH-1:0] title;
    logic                     update;
    logic                     sendingDone;
    logic [8*LINE_LENGTH:1]   line1;
    logic [8*LINE_LENGTH:1]   line2;
    logic                     sendText;
    logic                     busy;

    // Upstream producer plus text sender side.
    modport master (
        output value, title, update, sendingDone,
        input  line1, line2, sendText, busy
    );

    // Display formatter side.
    modport slave (
        input  value, title, update, sendingDone,
        output line1, line2, sendText, busy
    );
endinterface
`default_nettype wire

// File: rtl/lcd_value_display.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lcd_value_display
// Purpose  : Converts a binary value to decimal, formats two LCD text lines
//            and hands them to the text sender, coalescing later updates.
// Revision : 1.0
// ============================================================================
module lcd_value_display #(
    parameter int LINE_LENGTH = 16,
    parameter int VALUE_WIDTH = 16,
    parameter int DIGITS      = 5
) (
    input  wire logic          CLK,
    input  wire logic          RESET,
    lcd_value_display_if.slave bus
);
    localparam int CW = $clog2(VALUE_WIDTH + 1);
    localparam int LW = 8 * LINE_LENGTH;
    localparam int BW = 4 * DIGITS;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CONVERT   = 3'd1,
        S_FORMAT    = 3'd2,
        S_SEND      = 3'd3,
        S_WAIT_DONE = 3'd4
    } state_t;

    state_t                 state_q;
    logic [VALUE_WIDTH-1:0] shift_q;
    logic [BW-1:0]          bcd_q;
    logic [CW-1:0]          bit_cnt_q;
    logic [LW-1:0]          title_q;
    logic [VALUE_WIDTH-1:0] pend_value_q;
    logic [LW-1:0]          pend_title_q;
    logic                   pending_q;
    logic [LW:1]            line1_q;
    logic [LW:1]            line2_q;
    logic                   send_q;

    logic [BW-1:0]          bcd_adj;
    logic [BW-1:0]          bcd_d;
    logic [VALUE_WIDTH-1:0] shift_d;
    logic [LW:1]            line2_d;
    logic [VALUE_WIDTH-1:0] load_value_d;
    logic [LW-1:0]          load_title_d;
    logic                   shown;
    logic [3:0]             digit;

    // One double-dabble step: add 3 to every nibble >= 5, then shift left.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
    end

    // Right-aligned digits, leading zeros blanked except the units digit.
    always_comb begin
        line2_d = {LINE_LENGTH{8'h20}};
        shown   = 1'b0;
        digit   = 4'd0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            digit = bcd_q[4*i +: 4];
            if (digit != 4'd0 || i == 0) begin
                shown = 1'b1;
            end
            if (shown) begin
                line2_d[8*(i+1) -: 8] = 8'h30 + {4'h0, digit};
            end
        end
    end

    // A restart from WAIT_DONE uses a coincident update in preference to the stored one.
    always_comb begin
        if (state_q == S_WAIT_DONE && !bus.update) begin
            load_value_d = pend_value_q;
            load_title_d = pend_title_q;
        end else begin
            load_value_d = bus.value;
            load_title_d = bus.title;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            shift_q      <= '0;
            bcd_q        <= '0;
            bit_cnt_q    <= '0;
            title_q      <= '0;
            pend_value_q <= '0;
            pend_title_q <= '0;
            pending_q    <= 1'b0;
            line1_q      <= {LINE_LENGTH{8'h20}};
            line2_q      <= {LINE_LENGTH{8'h20}};
            send_q       <= 1'b0;
        end else begin
            send_q <= 1'b0;
            if (bus.update && state_q != S_IDLE) begin
                pend_value_q <= bus.value;
                pend_title_q <= bus.title;
                pending_q    <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (bus.update) begin
                        shift_q   <= load_value_d;
                        title_q   <= load_title_d;
                        bcd_q     <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    bcd_q     <= bcd_d;
                    shift_q   <= shift_d;
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CW'(VALUE_WIDTH - 1)) begin
                        state_q <= S_FORMAT;
                    end
                end
                S_FORMAT: begin
                    line1_q <= title_q;
                    line2_q <= line2_d;
                    send_q  <= 1'b1;
                    state_q <= S_SEND;
                end
                S_SEND: begin
                    state_q <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (bus.sendingDone) begin
                        if (pending_q || bus.update) begin
                            shift_q   <= load_value_d;
                            title_q   <= load_title_d;
                            bcd_q     <= '0;
                            bit_cnt_q <= '0;
                            pending_q <= 1'b0;
                            state_q   <= S_CONVERT;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.line1    = line1_q;
    assign bus.line2    = line2_q;
    assign bus.sendText = send_q;
    assign bus.busy     = (state_q != S_IDLE);

endmodule
`default_nettype wire
